// File: rtl/fp_cmul_arbiter.sv
// Round-robin front end for a fixed-latency complex multiplier shared by two requesters.
// Optional latency checker enabled by defining FP_CMUL_ARB_LATCHECK_EN.
module fp_cmul_arbiter #(
  parameter int LAT = 6,
  parameter int W   = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_req0_valid,
  output logic         io_req0_ready,
  input  logic [W-1:0] io_req0_op1_re,
  input  logic [W-1:0] io_req0_op1_im,
  input  logic [W-1:0] io_req0_op2_re,
  input  logic [W-1:0] io_req0_op2_im,
  input  logic         io_req1_valid,
  output logic         io_req1_ready,
  input  logic [W-1:0] io_req1_op1_re,
  input  logic [W-1:0] io_req1_op1_im,
  input  logic [W-1:0] io_req1_op2_re,
  input  logic [W-1:0] io_req1_op2_im,
  output logic         io_resp0_valid,
  output logic         io_resp1_valid,
  output logic [W-1:0] io_resp_re,
  output logic [W-1:0] io_resp_im,
  output logic         io_mul_ready,
  output logic [W-1:0] io_mul_op1_re,
  output logic [W-1:0] io_mul_op1_im,
  output logic [W-1:0] io_mul_op2_re,
  output logic [W-1:0] io_mul_op2_im,
  input  logic         io_mul_valid,
  input  logic [W-1:0] io_mul_res_re,
  input  logic [W-1:0] io_mul_res_im,
  input  logic         io_flush,
  output logic         io_flush_done,
  output logic         io_busy,
  output logic         io_err
);
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic            ptr;
  logic [LAT:1]    vld_pipe, id_pipe;
  logic [CW-1:0]   cnt;
  logic            gnt, gnt_id, exit_vld, exit_id;

  assign exit_vld = vld_pipe[LAT];
  assign exit_id  = id_pipe[LAT];

  always_comb begin
    state_nxt = state;
    gnt       = 1'b0;
    gnt_id    = 1'b0;
    case (state)
      RUN: begin
        // flush beats a simultaneous request; reset gates grants so ready stays low in reset
        if (io_flush) state_nxt = DRAIN;
        else if (reset && (io_req0_valid || io_req1_valid)) begin
          gnt    = 1'b1;
          gnt_id = (io_req0_valid && io_req1_valid) ? ~ptr : io_req1_valid;
        end
      end
      DRAIN:   if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign io_req0_ready = gnt & ~gnt_id;
  assign io_req1_ready = gnt & gnt_id;
  assign io_mul_ready  = gnt;
  assign io_mul_op1_re = (gnt && gnt_id) ? io_req1_op1_re : io_req0_op1_re;
  assign io_mul_op1_im = (gnt && gnt_id) ? io_req1_op1_im : io_req0_op1_im;
  assign io_mul_op2_re = (gnt && gnt_id) ? io_req1_op2_re : io_req0_op2_re;
  assign io_mul_op2_im = (gnt && gnt_id) ? io_req1_op2_im : io_req0_op2_im;

  assign io_resp0_valid = exit_vld & ~exit_id;
  assign io_resp1_valid = exit_vld & exit_id;
  assign io_resp_re     = io_mul_res_re;
  assign io_resp_im     = io_mul_res_im;
  assign io_flush_done  = (state == DONE);
  assign io_busy        = (cnt != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      ptr      <= 1'b1;
      vld_pipe <= '0;
      id_pipe  <= '0;
      cnt      <= '0;
    end else begin
      state       <= state_nxt;
      if (gnt) ptr <= gnt_id;
      vld_pipe[1] <= gnt;
      id_pipe[1]  <= gnt_id;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
      if (gnt && !exit_vld)      cnt <= cnt + CW'(1);
      else if (!gnt && exit_vld) cnt <= cnt - CW'(1);
    end
  end

`ifdef FP_CMUL_ARB_LATCHECK_EN
  logic err;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        err <= 1'b0;
    else if (io_mul_valid != exit_vld) err <= 1'b1;
  end
  assign io_err = err;
`else
  logic unused_mul_valid;
  assign unused_mul_valid = io_mul_valid;
  assign io_err           = 1'b0;
`endif
endmodule
